turn_resource_tracker: RTL
==========================

Name: turn_resource_tracker

Overview:
- Sequential accumulator directly downstream of the card decode output stage.
- Samples that stage's per-card outputs (buy, action, draw, gold/VP) once per card_go pulse.
- Maintains the active player's turn budget (actions, buys, coins), pending draws and running VP tally.
- Sequences the turn phases ACT -> BUY -> CLEAN -> DRAW and hands draw requests to the deck logic via a req/ack handshake.

Parameters:
- ACT_W, 4, width of actions_left counter
- BUY_W, 4, width of buys_left counter
- COIN_W, 6, width of coins counter
- DRAW_W, 4, width of draw_pending counter
- VP_W, 8, width of signed vp_total
- HAND_SIZE, 5, cards added to draw_pending at cleanup

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- turn_start  in  1  one-cycle pulse, begins a turn
- phase_end  in  1  one-cycle pulse, player ends current phase
- card_go  in  1  decode strobe; decode data is valid while high
- mode  in  3  START=1 ACTION=2 ACTIONEND=3 BUY=4 DRAW=5 ENDGAME=6
- buy_in  in  3  extra buys from card
- action_in  in  3  extra actions from card
- draw_in  in  3  extra draws from card
- gold_in  in  5  coins (ACTION/ACTIONEND); {valid,cost[3:0]} (BUY); {sign,0,mag[2:0]} (ENDGAME)
- draw_ack  in  1  deck delivered one card this cycle
- actions_left  out  ACT_W  remaining actions
- buys_left  out  BUY_W  remaining buys
- coins  out  COIN_W  spendable coins
- draw_pending  out  DRAW_W  cards still to draw
- draw_req  out  1  high while draw_pending != 0 in ACT or DRAW
- vp_total  out  VP_W  signed, two's complement VP sum
- phase  out  3  IDLE=0 ACT=1 BUY=2 CLEAN=3 DRAW=4
- act_err  out  1  one-cycle pulse: action card rejected
- buy_err  out  1  one-cycle pulse: purchase rejected
- turn_done  out  1  one-cycle pulse when DRAW completes

Behaviour:
- Reset (async, rst_n=0):
  - All counters, vp_total, phase, pulses and the card_go history flop = 0.
  - Reset mid-turn abandons the turn; no pending draw survives.
- Event detection:
  - event = card_go & ~card_go_q.
  - Exactly one update per card_go pulse regardless of pulse length.
  - Data sampled on the event cycle; results visible the next clock (1-cycle latency).
  - Error pulses assert the cycle after the event.
- Arithmetic:
  - All increments saturate at counter max; no wrap.
  - Decrements never go below 0.
  - vp_total saturates at signed min/max.
- IDLE:
  - turn_start -> ACT with actions_left=1, buys_left=1, coins=0.
  - Other inputs affect only vp_total (ENDGAME events).
- ACT:
  - ACTION event with actions_left==0: act_err, no state change.
  - Otherwise: actions_left = actions_left - 1 + action_in; buys += buy_in; coins += gold_in; draw_pending += draw_in.
  - ACTIONEND event: coins += gold_in, go to BUY.
  - phase_end: go to BUY.
- BUY:
  - ACTIONEND event: coins += gold_in.
  - BUY event is rejected with buy_err (no change) if gold_in[4]==0, buys_left==0, or gold_in[3:0] > coins.
  - Otherwise coins -= cost and buys_left -= 1; if buys_left becomes 0, go to CLEAN.
  - phase_end: go to CLEAN.
- CLEAN (one cycle):
  - actions_left, buys_left, coins = 0.
  - draw_pending += HAND_SIZE (saturating).
  - Go to DRAW.
- DRAW:
  - draw_ack decrements draw_pending.
  - When draw_pending reaches 0 (or is 0 on entry): go to IDLE and pulse turn_done.
- ENDGAME event, any phase:
  - vp_total += gold_in[4] ? -gold_in[2:0] : +gold_in[2:0].
  - gold_in[3] ignored.
- Ignored inputs:
  - Modes START, DRAW, 0, 7, and modes invalid for the current phase: no change, no error.
  - turn_start outside IDLE.
  - draw_ack when draw_pending==0 or phase not ACT/DRAW.
- Simultaneous events:
  - Card event and phase_end in the same cycle: the event is applied using the pre-transition phase, then the transition is taken.
  - draw_ack and an ACTION event with draw_in in the same cycle: draw_pending nets to +draw_in-1.
  - A purchase that zeroes buys_left and phase_end in the same cycle: single transition to CLEAN.

Test Plan:
- Reset then turn_start -> phase=ACT, actions_left=1, buys_left=1, coins=0, vp_total=0.
- ACT, ACTION event action_in=2, draw_in=2, gold_in=1 -> actions_left=2, coins=1, draw_pending=2, draw_req=1; two draw_ack -> draw_pending=0, draw_req=0.
- ACT, ACTION event with actions_left=0 -> act_err single pulse, all counters unchanged; card_go held high 4 cycles -> only one update.
- BUY, coins=5: BUY event gold_in=5'b1_0110 -> buy_err, coins=5; then gold_in=5'b1_0011 -> coins=2, buys_left=0, phase=CLEAN, then DRAW with draw_pending=5.
- DRAW: 5 draw_ack -> phase=IDLE, turn_done pulses once.
- ENDGAME events gold_in=5'b0_0011, then 5'b1_0001 -> vp_total=3, then 2; 60 events of +3 -> vp_total saturates at 127.
- Assert rst_n=0 mid-BUY, asynchronously -> all outputs 0 immediately, phase=IDLE.

Source files
------------

// File: rtl/turn_resource_tracker_if.sv
// Card-decode and deck-handshake signal bundle for turn_resource_tracker.
// The master side drives decode data and draw_ack; the slave side is the tracker.
interface turn_resource_tracker_if #(
  parameter int unsigned ACT_W  = 4,
  parameter int unsigned BUY_W  = 4,
  parameter int unsigned COIN_W = 6,
  parameter int unsigned DRAW_W = 4,
  parameter int unsigned VP_W   = 8
);
  logic                    turn_start;
  logic                    phase_end;
  logic                    card_go;
  logic [2:0]              mode;
  logic [2:0]              buy_in;
  logic [2:0]              action_in;
  logic [2:0]              draw_in;
  logic [4:0]              gold_in;
  logic                    draw_ack;

  logic [ACT_W-1:0]        actions_left;
  logic [BUY_W-1:0]        buys_left;
  logic [COIN_W-1:0]       coins;
  logic [DRAW_W-1:0]       draw_pending;
  logic                    draw_req;
  logic signed [VP_W-1:0]  vp_total;
  logic [2:0]              phase;
  logic                    act_err;
  logic                    buy_err;
  logic                    turn_done;

  modport master (
    output turn_start, phase_end, card_go, mode, buy_in, action_in, draw_in, gold_in, draw_ack,
    input  actions_left, buys_left, coins, draw_pending, draw_req, vp_total, phase,
           act_err, buy_err, turn_done
  );

  modport slave (
    input  turn_start, phase_end, card_go, mode, buy_in, action_in, draw_in, gold_in, draw_ack,
    output actions_left, buys_left, coins, draw_pending, draw_req, vp_total, phase,
           act_err, buy_err, turn_done
  );
endinterface

// File: rtl/turn_resource_tracker.sv
// Per-turn budget tracker: accumulates decoded card effects once per card_go pulse,
// sequences ACT -> BUY -> CLEAN -> DRAW and requests draws from the deck.
module turn_resource_tracker #(
  parameter int unsigned ACT_W     = 4,
  parameter int unsigned BUY_W     = 4,
  parameter int unsigned COIN_W    = 6,
  parameter int unsigned DRAW_W    = 4,
  parameter int unsigned VP_W      = 8,
  parameter int unsigned HAND_SIZE = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  turn_resource_tracker_if.slave bus
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_ACT   = 3'd1;
  localparam logic [2:0] PH_BUY   = 3'd2;
  localparam logic [2:0] PH_CLEAN = 3'd3;
  localparam logic [2:0] PH_DRAW  = 3'd4;

  localparam logic [2:0] M_ACTION    = 3'd2;
  localparam logic [2:0] M_ACTIONEND = 3'd3;
  localparam logic [2:0] M_BUY       = 3'd4;
  localparam logic [2:0] M_ENDGAME   = 3'd6;

  localparam int unsigned ACT_MAX  = 2**ACT_W - 1;
  localparam int unsigned BUY_MAX  = 2**BUY_W - 1;
  localparam int unsigned COIN_MAX = 2**COIN_W - 1;
  localparam int unsigned DRAW_MAX = 2**DRAW_W - 1;
  localparam int          VP_MAX   = 2**(VP_W-1) - 1;
  localparam int          VP_MIN   = -(2**(VP_W-1));

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  logic [2:0]             phase_q,   phase_d;
  logic [ACT_W-1:0]       actions_q, actions_d;
  logic [BUY_W-1:0]       buys_q,    buys_d;
  logic [COIN_W-1:0]      coins_q,   coins_d;
  logic [DRAW_W-1:0]      pend_q,    pend_d;
  logic signed [VP_W-1:0] vp_q,      vp_d;
  logic                   act_err_q, act_err_d;
  logic                   buy_err_q, buy_err_d;
  logic                   done_q,    done_d;
  logic                   card_go_q;

  logic                   evt;
  logic                   ack_ok;
  logic [DRAW_W-1:0]      pend_base;
  int                     vp_delta;
  int                     vp_sum;

  assign evt    = bus.card_go & ~card_go_q;
  assign ack_ok = bus.draw_ack && (pend_q != '0) && (phase_q == PH_ACT || phase_q == PH_DRAW);

  always_comb begin
    phase_d   = phase_q;
    actions_d = actions_q;
    buys_d    = buys_q;
    coins_d   = coins_q;
    vp_d      = vp_q;
    act_err_d = 1'b0;
    buy_err_d = 1'b0;
    done_d    = 1'b0;
    pend_base = ack_ok ? pend_q - DRAW_W'(1) : pend_q;
    pend_d    = pend_base;

    vp_delta      = 0;
    vp_delta[2:0] = bus.gold_in[2:0];
    if (bus.gold_in[4]) vp_delta = -vp_delta;
    vp_sum = int'(vp_q) + vp_delta;
    if (evt && bus.mode == M_ENDGAME) begin
      if (vp_sum > VP_MAX)      vp_d = VP_W'(VP_MAX);
      else if (vp_sum < VP_MIN) vp_d = VP_W'(VP_MIN);
      else                      vp_d = VP_W'(vp_sum);
    end

    // Card event uses the current phase; phase_end then overrides the next phase.
    case (phase_q)
      PH_IDLE: begin
        if (bus.turn_start) begin
          phase_d   = PH_ACT;
          actions_d = ACT_W'(1);
          buys_d    = BUY_W'(1);
          coins_d   = '0;
        end
      end
      PH_ACT: begin
        if (evt && bus.mode == M_ACTION) begin
          if (actions_q == '0) begin
            act_err_d = 1'b1;
          end else begin
            actions_d = ACT_W'(sat(32'(actions_q) - 32'd1 + 32'(bus.action_in), ACT_MAX));
            buys_d    = BUY_W'(sat(32'(buys_q) + 32'(bus.buy_in), BUY_MAX));
            coins_d   = COIN_W'(sat(32'(coins_q) + 32'(bus.gold_in), COIN_MAX));
            pend_d    = DRAW_W'(sat(32'(pend_base) + 32'(bus.draw_in), DRAW_MAX));
          end
        end else if (evt && bus.mode == M_ACTIONEND) begin
          coins_d = COIN_W'(sat(32'(coins_q) + 32'(bus.gold_in), COIN_MAX));
          phase_d = PH_BUY;
        end
        if (bus.phase_end) phase_d = PH_BUY;
      end
      PH_BUY: begin
        if (evt && bus.mode == M_ACTIONEND) begin
          coins_d = COIN_W'(sat(32'(coins_q) + 32'(bus.gold_in), COIN_MAX));
        end else if (evt && bus.mode == M_BUY) begin
          if (!bus.gold_in[4] || buys_q == '0 || 32'(bus.gold_in[3:0]) > 32'(coins_q)) begin
            buy_err_d = 1'b1;
          end else begin
            coins_d = coins_q - COIN_W'(bus.gold_in[3:0]);
            buys_d  = buys_q - BUY_W'(1);
            if (buys_q == BUY_W'(1)) phase_d = PH_CLEAN;
          end
        end
        if (bus.phase_end) phase_d = PH_CLEAN;
      end
      PH_CLEAN: begin
        actions_d = '0;
        buys_d    = '0;
        coins_d   = '0;
        pend_d    = DRAW_W'(sat(32'(pend_q) + HAND_SIZE, DRAW_MAX));
        phase_d   = PH_DRAW;
      end
      PH_DRAW: begin
        if (pend_base == '0) begin
          phase_d = PH_IDLE;
          done_d  = 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_IDLE;
      actions_q <= '0;
      buys_q    <= '0;
      coins_q   <= '0;
      pend_q    <= '0;
      vp_q      <= '0;
      act_err_q <= 1'b0;
      buy_err_q <= 1'b0;
      done_q    <= 1'b0;
      card_go_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      actions_q <= actions_d;
      buys_q    <= buys_d;
      coins_q   <= coins_d;
      pend_q    <= pend_d;
      vp_q      <= vp_d;
      act_err_q <= act_err_d;
      buy_err_q <= buy_err_d;
      done_q    <= done_d;
      card_go_q <= bus.card_go;
    end
  end

  assign bus.phase        = phase_q;
  assign bus.actions_left = actions_q;
  assign bus.buys_left    = buys_q;
  assign bus.coins        = coins_q;
  assign bus.draw_pending = pend_q;
  assign bus.vp_total     = vp_q;
  assign bus.act_err      = act_err_q;
  assign bus.buy_err      = buy_err_q;
  assign bus.turn_done    = done_q;
  assign bus.draw_req     = (pend_q != '0) && (phase_q == PH_ACT || phase_q == PH_DRAW);

endmodule
